// File: rtl/redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// redirect_ctrl_if
//  Bundles the EX-side event inputs, the CSR trap-entry handshake and the
//  fetch redirect handshake seen by redirect_ctrl.
//  Modports:
//    master : redirect_ctrl side (consumes EX/CSR/fetch inputs, drives
//             flushes, stall, trap request and redirect)
//    slave  : pipeline/CSR/fetch side (the mirror image)
//  Signals:
//    ex_valid, ex_pc, ex_pcn, ex_exception   EX-stage resolved instruction
//    trap_vector, csr_ack                    CSR unit trap-entry response
//    if_ready                                fetch accepts redirect
//    flush_if, flush_id, flush_ex            stage squash controls
//    stall_pipe                              freeze PC/pipeline registers
//    trap_req, trap_cause, trap_epc          CSR trap-entry request
//    redirect_valid, redirect_pc             redirect offered to fetch
// -----------------------------------------------------------------------------
interface redirect_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int EXC_BITS   = 4
);
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_pcn;
    logic [EXC_BITS-1:0]   ex_exception;
    logic [DATA_WIDTH-1:0] trap_vector;
    logic                  csr_ack;
    logic                  if_ready;
    logic                  flush_if;
    logic                  flush_id;
    logic                  flush_ex;
    logic                  stall_pipe;
    logic                  trap_req;
    logic [EXC_BITS-1:0]   trap_cause;
    logic [DATA_WIDTH-1:0] trap_epc;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    modport master (
        input  ex_valid, ex_pc, ex_pcn, ex_exception, trap_vector, csr_ack, if_ready,
        output flush_if, flush_id, flush_ex, stall_pipe, trap_req, trap_cause,
               trap_epc, redirect_valid, redirect_pc
    );

    modport slave (
        output ex_valid, ex_pc, ex_pcn, ex_exception, trap_vector, csr_ack, if_ready,
        input  flush_if, flush_id, flush_ex, stall_pipe, trap_req, trap_cause,
               trap_epc, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/redirect_ctrl.sv
// -----------------------------------------------------------------------------
// redirect_ctrl
//  Sequences control-flow redirects for the 5-stage pipeline. Watches the EX
//  resolved PC pair and exception flags; on an exception it requests CSR trap
//  entry and then redirects fetch to the trap vector, on a mispredict it
//  redirects fetch to the resolved next PC. IF/ID are flushed and the pipe is
//  stalled for the whole sequence; EX is flushed for one cycle on exceptions.
//
//  Optional feature macro: REDIRECT_PERF_EN adds saturating mispredict/trap
//  counters (ports mispredict_cnt, trap_cnt).
//
//  Ports:
//    clk, rst_n        clock (rising edge), asynchronous active-low reset
//    bus               redirect_ctrl_if.master (EX/CSR/fetch signals)
//    state_dbg         current FSM state (0 IDLE, 1 TRAP_WAIT, 2 REDIRECT)
//    mispredict_cnt    (REDIRECT_PERF_EN) accepted mispredict count
//    trap_cnt          (REDIRECT_PERF_EN) accepted exception count
//
//  Handshakes: redirect_valid is raised with redirect_pc and both are held
//  stable until a cycle where redirect_valid && if_ready (the transfer); the
//  trap request works the same way with trap_req/csr_ack. Neither valid waits
//  on its ready before asserting.
// -----------------------------------------------------------------------------
module redirect_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int EXC_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    redirect_ctrl_if.master      bus,
    output logic [1:0]           state_dbg
`ifdef REDIRECT_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] mispredict_cnt,
    output logic [CNT_WIDTH-1:0] trap_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // CNT_WIDTH only sizes the optional counters; this empty block keeps it
    // referenced when they are compiled out.
    if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
    end

    // Event detection; only acted upon in IDLE, everything else is wrong-path.
    logic                  exc, misp, take_exc, take_misp;
    logic [EXC_BITS-1:0]   exc_onehot;
    logic [DATA_WIDTH-1:0] pc_plus4;

    assign pc_plus4   = bus.ex_pc + DATA_WIDTH'(4);   // wraps modulo 2^DATA_WIDTH
    assign exc        = |bus.ex_exception;
    assign misp       = (pc_plus4 != bus.ex_pcn);
    // x & -x isolates the lowest set bit: lowest exception index wins.
    assign exc_onehot = bus.ex_exception & (~bus.ex_exception + EXC_BITS'(1));
    assign take_exc   = (state_q == IDLE) && bus.ex_valid && exc;
    assign take_misp  = (state_q == IDLE) && bus.ex_valid && !exc && misp;

    // Output registers
    logic                  busy_q, busy_d;
    logic                  flush_ex_q, flush_ex_d;
    logic                  trap_req_q, trap_req_d;
    logic [EXC_BITS-1:0]   trap_cause_q, trap_cause_d;
    logic [DATA_WIDTH-1:0] trap_epc_q, trap_epc_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rpc_q, rpc_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_exc)       state_d = TRAP_WAIT;
                else if (take_misp) state_d = REDIRECT;
            end
            TRAP_WAIT: if (bus.csr_ack)  state_d = REDIRECT;
            REDIRECT:  if (bus.if_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        busy_d       = (state_d != IDLE);
        flush_ex_d   = 1'b0;
        trap_req_d   = trap_req_q;
        trap_cause_d = trap_cause_q;
        trap_epc_d   = trap_epc_q;
        rvalid_d     = rvalid_q;
        rpc_d        = rpc_q;
        case (state_q)
            IDLE: begin
                if (take_exc) begin
                    trap_req_d   = 1'b1;
                    trap_cause_d = exc_onehot;
                    trap_epc_d   = bus.ex_pc;
                    flush_ex_d   = 1'b1;
                end else if (take_misp) begin
                    rvalid_d = 1'b1;
                    rpc_d    = bus.ex_pcn;
                end
            end
            TRAP_WAIT: begin
                if (bus.csr_ack) begin
                    trap_req_d = 1'b0;
                    rvalid_d   = 1'b1;
                    rpc_d      = {bus.trap_vector[DATA_WIDTH-1:2], 2'b00};
                end
            end
            REDIRECT: if (bus.if_ready) rvalid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= 1'b0;
            flush_ex_q   <= 1'b0;
            trap_req_q   <= 1'b0;
            trap_cause_q <= '0;
            trap_epc_q   <= '0;
            rvalid_q     <= 1'b0;
            rpc_q        <= '0;
        end else begin
            busy_q       <= busy_d;
            flush_ex_q   <= flush_ex_d;
            trap_req_q   <= trap_req_d;
            trap_cause_q <= trap_cause_d;
            trap_epc_q   <= trap_epc_d;
            rvalid_q     <= rvalid_d;
            rpc_q        <= rpc_d;
        end
    end

    assign bus.flush_if       = busy_q;
    assign bus.flush_id       = busy_q;
    assign bus.stall_pipe     = busy_q;
    assign bus.flush_ex       = flush_ex_q;
    assign bus.trap_req       = trap_req_q;
    assign bus.trap_cause     = trap_cause_q;
    assign bus.trap_epc       = trap_epc_q;
    assign bus.redirect_valid = rvalid_q;
    assign bus.redirect_pc    = rpc_q;
    assign state_dbg          = state_q;

`ifdef REDIRECT_PERF_EN
    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_cnt <= '0;
            trap_cnt       <= '0;
        end else begin
            if (take_misp && (mispredict_cnt != {CNT_WIDTH{1'b1}}))
                mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
            if (take_exc && (trap_cnt != {CNT_WIDTH{1'b1}}))
                trap_cnt <= trap_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_redirect_ctrl
//  Self-checking bench for redirect_ctrl: directed scenarios with literal
//  expectations plus randomized traffic compared every cycle against a
//  behavioural model.
// -----------------------------------------------------------------------------
module tb_redirect_ctrl;
    localparam int DW = 64;
    localparam int EB = 4;
`ifdef REDIRECT_PERF_EN
    localparam int CW = 2;
`else
    localparam int CW = 32;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    redirect_ctrl_if #(.DATA_WIDTH(DW), .EXC_BITS(EB)) bus ();
    logic [1:0] state_dbg;
`ifdef REDIRECT_PERF_EN
    logic [CW-1:0] mispredict_cnt, trap_cnt;
`endif

    redirect_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .EXC_BITS(EB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef REDIRECT_PERF_EN
        ,
        .mispredict_cnt (mispredict_cnt),
        .trap_cnt       (trap_cnt)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 waiting for CSR, 2 offering redirect
    int            m_mode = 0;
    logic          e_busy = 0, e_flush_ex = 0, e_trap_req = 0, e_rvalid = 0;
    logic [EB-1:0] e_cause = '0;
    logic [DW-1:0] e_epc = '0, e_rpc = '0;
    int            m_mcnt = 0, m_tcnt = 0;
    int            cnt_max = (CW >= 31) ? 32'h7fff_ffff : ((1 << CW) - 1);
    int            low_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; e_busy = 0; e_flush_ex = 0; e_trap_req = 0; e_rvalid = 0;
            e_cause = '0; e_epc = '0; e_rpc = '0; m_mcnt = 0; m_tcnt = 0;
        end else begin
            e_flush_ex = 0;
            if (m_mode == 0) begin
                if (bus.ex_valid && bus.ex_exception != 0) begin
                    low_idx = EB;
                    for (int i = EB - 1; i >= 0; i--)
                        if (bus.ex_exception[i]) low_idx = i;
                    e_cause    = '0;
                    e_cause[low_idx] = 1'b1;
                    e_epc      = bus.ex_pc;
                    e_trap_req = 1;
                    e_flush_ex = 1;
                    m_mode     = 1;
                    if (m_tcnt < cnt_max) m_tcnt++;
                end else if (bus.ex_valid && (bus.ex_pc + 64'd4) != bus.ex_pcn) begin
                    e_rvalid = 1;
                    e_rpc    = bus.ex_pcn;
                    m_mode   = 2;
                    if (m_mcnt < cnt_max) m_mcnt++;
                end
            end else if (m_mode == 1) begin
                if (bus.csr_ack) begin
                    e_trap_req = 0;
                    e_rvalid   = 1;
                    e_rpc      = bus.trap_vector & ~64'd3;
                    m_mode     = 2;
                end
            end else begin
                if (bus.if_ready) begin
                    e_rvalid = 0;
                    m_mode   = 0;
                end
            end
            e_busy = (m_mode != 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        chk("flush_if",       bus.flush_if,       e_busy);
        chk("flush_id",       bus.flush_id,       e_busy);
        chk("stall_pipe",     bus.stall_pipe,     e_busy);
        chk("flush_ex",       bus.flush_ex,       e_flush_ex);
        chk("trap_req",       bus.trap_req,       e_trap_req);
        chk("trap_cause",     bus.trap_cause,     e_cause);
        chk("trap_epc",       bus.trap_epc,       e_epc);
        chk("redirect_valid", bus.redirect_valid, e_rvalid);
        if (e_rvalid) chk("redirect_pc", bus.redirect_pc, e_rpc);
`ifdef REDIRECT_PERF_EN
        chk("mispredict_cnt", mispredict_cnt, m_mcnt);
        chk("trap_cnt",       trap_cnt,       m_tcnt);
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        bus.ex_valid     = 0;
        bus.ex_pc        = '0;
        bus.ex_pcn       = '0;
        bus.ex_exception = '0;
        bus.trap_vector  = '0;
        bus.csr_ack      = 0;
        bus.if_ready     = 0;
    endtask

    task automatic drive_ex(input logic [DW-1:0] pc, input logic [DW-1:0] pcn,
                            input logic [EB-1:0] exc);
        bus.ex_valid     = 1;
        bus.ex_pc        = pc;
        bus.ex_pcn       = pcn;
        bus.ex_exception = exc;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] r_pc;
        rst_n = 0;
        drive_idle();
        repeat (3) cyc();
        chk("reset_flush_if", bus.flush_if, 0);
        chk("reset_redirect_valid", bus.redirect_valid, 0);
        chk("reset_trap_epc", bus.trap_epc, 0);
        chk("reset_state", state_dbg, 0);
        rst_n = 1;
        cyc();

        // 1: correctly predicted sequential instruction
        drive_ex(64'h1000, 64'h1004, 4'b0000);
        cyc();
        bus.ex_valid = 0;
        chk("t1_flush_if", bus.flush_if, 0);
        chk("t1_stall", bus.stall_pipe, 0);
        chk("t1_redirect_valid", bus.redirect_valid, 0);

        // 2: mispredict, fetch busy for 3 cycles, wrong-path exception ignored
        drive_ex(64'h1000, 64'h2000, 4'b0000);
        bus.if_ready = 0;
        cyc();                                  // T+1
        bus.ex_valid = 0;
        chk("t2_rv_t1", bus.redirect_valid, 1);
        chk("t2_rpc_t1", bus.redirect_pc, 64'h2000);
        chk("t2_flush_t1", bus.flush_if, 1);
        cyc();                                  // T+2
        drive_ex(64'h7000, 64'h7004, 4'b0001);  // wrong path
        chk("t2_flush_t2", bus.flush_id, 1);
        cyc();                                  // T+3
        bus.ex_valid = 0;
        chk("t2_rpc_t3", bus.redirect_pc, 64'h2000);
        chk("t2_no_trap", bus.trap_req, 0);
        cyc();                                  // T+4
        bus.if_ready = 1;
        chk("t2_flush_t4", bus.flush_if, 1);
        cyc();                                  // T+5
        bus.if_ready = 0;
        chk("t2_flush_done", bus.flush_if, 0);
        chk("t2_rv_done", bus.redirect_valid, 0);
        chk("t2_idle", state_dbg, 0);

        // 3: exception beats mispredict, lowest bit wins, csr_ack at T+3
        drive_ex(64'h3000, 64'h5000, 4'b0110);
        cyc();                                  // T+1
        bus.ex_valid    = 0;
        bus.trap_vector = 64'h8000_0003;
        chk("t3_trap_req", bus.trap_req, 1);
        chk("t3_cause", bus.trap_cause, 4'b0010);
        chk("t3_epc", bus.trap_epc, 64'h3000);
        chk("t3_flush_ex", bus.flush_ex, 1);
        chk("t3_rv_t1", bus.redirect_valid, 0);
        cyc();                                  // T+2
        chk("t3_flush_ex_pulse", bus.flush_ex, 0);
        chk("t3_trap_hold", bus.trap_req, 1);
        cyc();                                  // T+3
        bus.csr_ack = 1;
        chk("t3_trap_hold3", bus.trap_req, 1);
        cyc();                                  // T+4
        bus.csr_ack     = 0;
        bus.trap_vector = 64'hdead_beef_0000_0010;
        bus.if_ready    = 1;
        chk("t3_trap_drop", bus.trap_req, 0);
        chk("t3_rv", bus.redirect_valid, 1);
        chk("t3_rpc", bus.redirect_pc, 64'h8000_0000);
        cyc();                                  // T+5
        bus.if_ready = 0;
        chk("t3_rv_done", bus.redirect_valid, 0);
        chk("t3_cause_kept", bus.trap_cause, 4'b0010);
        chk("t3_epc_kept", bus.trap_epc, 64'h3000);

        // 4: PC wrap is not a mispredict
        drive_ex(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4'b0000);
        cyc();
        bus.ex_valid = 0;
        chk("t4_flush_if", bus.flush_if, 0);
        chk("t4_rv", bus.redirect_valid, 0);

        // 5: asynchronous reset during TRAP_WAIT
        drive_ex(64'h4000, 64'h4004, 4'b1000);
        cyc();
        bus.ex_valid = 0;
        chk("t5_trap_req", bus.trap_req, 1);
        chk("t5_cause", bus.trap_cause, 4'b1000);
        #3;
        rst_n = 0;
        #1;
        chk("t5_rst_trap_req", bus.trap_req, 0);
        chk("t5_rst_flush_if", bus.flush_if, 0);
        chk("t5_rst_stall", bus.stall_pipe, 0);
        chk("t5_rst_cause", bus.trap_cause, 0);
        chk("t5_rst_epc", bus.trap_epc, 0);
        chk("t5_rst_state", state_dbg, 0);
        cyc();
        rst_n = 1;
        cyc();

        // minimum trap latency: csr_ack already high at T+1
        drive_ex(64'h5000, 64'h5004, 4'b0100);
        bus.csr_ack     = 1;
        bus.trap_vector = 64'h0000_0000_0000_0207;
        cyc();                                  // T+1
        bus.ex_valid = 0;
        chk("lat_trap_req", bus.trap_req, 1);
        chk("lat_rv_t1", bus.redirect_valid, 0);
        cyc();                                  // T+2
        bus.csr_ack  = 0;
        bus.if_ready = 1;
        chk("lat_rv_t2", bus.redirect_valid, 1);
        chk("lat_rpc", bus.redirect_pc, 64'h204);
        cyc();
        bus.if_ready = 0;

        // randomized traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            r_pc = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            bus.ex_valid = ($urandom_range(0, 3) != 0);
            bus.ex_pc    = r_pc;
            case ($urandom_range(0, 3))
                0, 1: bus.ex_pcn = r_pc + 64'd4;
                2:    bus.ex_pcn = r_pc + 64'd8;
                default: bus.ex_pcn = {$urandom, $urandom};
            endcase
            bus.ex_exception = ($urandom_range(0, 3) == 0) ? EB'($urandom_range(1, 15)) : '0;
            bus.trap_vector  = {$urandom, $urandom};
            bus.csr_ack      = ($urandom_range(0, 2) == 0);
            bus.if_ready     = ($urandom_range(0, 2) == 0);
            cyc();
        end
        drive_idle();
        bus.csr_ack  = 1;
        bus.if_ready = 1;
        repeat (4) cyc();
        drive_idle();

`ifdef REDIRECT_PERF_EN
        // 6: counter saturation with CNT_WIDTH=2
        pulse_reset();
        bus.if_ready = 1;
        bus.csr_ack  = 1;
        for (int k = 0; k < 5; k++) begin
            drive_ex(64'h100 * (k + 1), 64'h9000, 4'b0000);
            cyc();
            bus.ex_valid = 0;
            cyc();
        end
        drive_ex(64'h6000, 64'h6004, 4'b0001);
        cyc();
        bus.ex_valid = 0;
        repeat (3) cyc();
        chk("t6_mispredict_cnt", mispredict_cnt, 3);
        chk("t6_trap_cnt", trap_cnt, 1);
        drive_idle();
`endif

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
